// File: rtl/syn_fifo_wr_arb.sv
// Round-robin write arbiter sharing one synchronous FIFO write port among
// NUM_REQ valid/ready requesters. A grant lasts for one packet (ending on
// req_last) or at most MAX_BURST beats, whichever comes first. Every new
// grant costs one IDLE arbitration cycle.
module syn_fifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_we,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_nxt, gid_nxt, pick;
  logic [CNTW-1:0] beat_cnt, cnt_nxt;
  logic            any_valid;
  logic            g_valid, g_last;
  logic            accept, release_now;
  int unsigned     idx;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping
  // NUM_REQ-1 -> 0 (modulo keeps non-power-of-two counts in range).
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any_valid && req_valid[idx[IDW-1:0]]) begin
        any_valid = 1'b1;
        pick      = idx[IDW-1:0];
      end
    end
  end

  // Route the granted requester's valid/last/data and return its ready.
  always_comb begin
    g_valid    = 1'b0;
    g_last     = 1'b0;
    fifo_wdata = req_data[WIDTH-1:0];
    req_ready  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        g_valid      = req_valid[k];
        g_last       = req_last[k];
        fifo_wdata   = req_data[k*WIDTH +: WIDTH];
        req_ready[k] = (state == BUSY) && !fifo_full;
      end
    end
  end

  assign grant_valid = (state == BUSY);
  assign accept      = (state == BUSY) && g_valid && !fifo_full;
  assign fifo_we     = accept;
  assign release_now = accept && (g_last || (beat_cnt == CNTW'(MAX_BURST - 1)));

  // Next-state: arbitrate in IDLE, count beats and release in BUSY.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (any_valid) begin
          gid_nxt   = pick;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rr_nxt    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (accept) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
    endcase
  end

  // State register; reset abandons any burst and restarts priority at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= gid_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

endmodule
